// File: rtl/touch_pkg.sv
// touch_pkg: register map, FSM state types and command defaults for the touch reader
package touch_pkg;
  localparam int RES_W = 12;
  localparam int SHIFT_HALVES = 48;
  localparam logic [7:0] REG_CTRL = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_XDATA = 8'h08;
  localparam logic [7:0] REG_YDATA = 8'h0C;
  localparam logic [7:0] CMD_X_DEF = 8'hD0;
  localparam logic [7:0] CMD_Y_DEF = 8'h90;
  typedef enum logic [2:0] {F_IDLE, F_SETUP, F_SHIFT, F_HOLD, F_GAP} frame_state_t;
  typedef enum logic [1:0] {S_IDLE, S_X, S_Y, S_DONE} scan_state_t;
endpackage

// File: rtl/touch_spi_frame.sv
// touch_spi_frame: one 24-clock serial frame (8-bit command out, 12-bit result in)
module touch_spi_frame
  import touch_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       cmd,
  input  logic             dout,
  output logic             dclk,
  output logic             cs_n,
  output logic             din,
  output logic             done,
  output logic [RES_W-1:0] result
);
  localparam int CW = $clog2(CLK_DIV);
  frame_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [5:0] half;
  logic tick;
  assign tick = cnt == '0;
  always_comb begin
    state_nx = state;
    case (state)
      F_IDLE:  state_nx = start ? F_SETUP : F_IDLE;
      F_SETUP: state_nx = tick ? F_SHIFT : F_SETUP;
      F_SHIFT: state_nx = (tick && half == 6'(SHIFT_HALVES - 1)) ? F_HOLD : F_SHIFT;
      F_HOLD:  state_nx = tick ? F_GAP : F_HOLD;
      F_GAP:   state_nx = tick ? (start ? F_SETUP : F_IDLE) : F_GAP;
      default: state_nx = F_IDLE;
    endcase
  end
  // half counts SHIFT half-periods: even = dclk low, odd = dclk high; rising edge n enters half 2n-1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= F_IDLE;
      cnt    <= '0;
      half   <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == F_IDLE || tick) ? CW'(CLK_DIV - 1) : cnt - 1'b1;
      half  <= state != F_SHIFT ? '0 : tick ? half + 1'b1 : half;
      if (state == F_SHIFT && tick && !half[0] && half[5:1] >= 5'd9 && half[5:1] <= 5'd20)
        result <= {result[RES_W-2:0], dout};
    end
  assign cs_n = !(state inside {F_SETUP, F_SHIFT, F_HOLD});
  assign dclk = state == F_SHIFT && half[0];
  assign din  = state == F_SHIFT && half[5:4] == 2'b00 && cmd[~half[3:1]];
  assign done = state == F_GAP && tick;
endmodule

// File: rtl/ahb_touch_reader.sv
// ahb_touch_reader: AHB-Lite slave that scans X/Y from a serial touch controller
module ahb_touch_reader
  import touch_pkg::*;
#(
  parameter int         CLK_DIV = 25,
  parameter logic [7:0] CMD_X   = CMD_X_DEF,
  parameter logic [7:0] CMD_Y   = CMD_Y_DEF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        touch_dout,
  input  logic        touch_penirq_n,
  output logic        touch_dclk,
  output logic        touch_cs,
  output logic        touch_din,
  output logic        irq
);
  logic r_sel, r_write, r_trans, auto_en, irq_en, done;
  logic wr, start_wr, clr_wr, go, frame_start, frame_done, busy, pen_down;
  logic [7:0] r_addr;
  logic [1:0] pen_sync;
  logic [RES_W-1:0] result, x_tmp, xdata, ydata;
  scan_state_t scan, scan_nx;
  logic unused;
  assign unused = ^{HADDR[31:8], HSIZE, HTRANS[0], HWDATA[31:3]};
  assign wr          = r_sel & r_write & r_trans;
  assign start_wr    = wr && r_addr == REG_CTRL && HWDATA[0];
  assign clr_wr      = wr && r_addr == REG_STATUS && HWDATA[1];
  assign busy        = scan != S_IDLE;
  assign pen_down    = !pen_sync[1];
  assign go          = scan == S_IDLE && (start_wr || (auto_en && pen_down && !done));
  assign frame_start = go || (scan == S_X && frame_done);
  always_comb begin
    scan_nx = scan;
    case (scan)
      S_IDLE:  scan_nx = go ? S_X : S_IDLE;
      S_X:     scan_nx = frame_done ? S_Y : S_X;
      S_Y:     scan_nx = frame_done ? S_DONE : S_Y;
      default: scan_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      r_sel    <= 1'b0;
      r_write  <= 1'b0;
      r_trans  <= 1'b0;
      r_addr   <= '0;
      auto_en  <= 1'b0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      pen_sync <= 2'b11;
      scan     <= S_IDLE;
      x_tmp    <= '0;
      xdata    <= '0;
      ydata    <= '0;
    end else begin
      if (HREADY) begin
        r_sel   <= HSEL;
        r_write <= HWRITE;
        r_trans <= HTRANS[1];
        r_addr  <= HADDR[7:0];
      end
      pen_sync <= {pen_sync[0], touch_penirq_n};
      if (wr && r_addr == REG_CTRL) {irq_en, auto_en} <= HWDATA[2:1];
      done <= (scan == S_DONE) | (done & !clr_wr);
      scan <= scan_nx;
      if (scan == S_X && frame_done) x_tmp <= result;
      if (scan == S_DONE) {xdata, ydata} <= {x_tmp, result};
    end
  assign HREADYOUT = 1'b1;
  assign irq = done & irq_en;
  assign HRDATA = r_addr == REG_CTRL   ? {29'b0, irq_en, auto_en, 1'b0} :
                  r_addr == REG_STATUS ? {29'b0, pen_down, done, busy} :
                  r_addr == REG_XDATA  ? {20'b0, xdata} :
                  r_addr == REG_YDATA  ? {20'b0, ydata} : '0;
  touch_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .start (frame_start),
    .cmd   (scan == S_Y ? CMD_Y : CMD_X),
    .dout  (touch_dout),
    .dclk  (touch_dclk),
    .cs_n  (touch_cs),
    .din   (touch_din),
    .done  (frame_done),
    .result(result)
  );
endmodule
